// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: blank pattern,
// active-low hex decode table and the digit-slot state type.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n holds the gfedcba pattern (active-low) for hex digit n.
    localparam logic [15:0][6:0] SEG_DECODE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low segment decoder (seg_n[6:0] = gfedcba).
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_DECODE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with
// per-slot anti-ghost blanking and frame-aligned double-buffered display data.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_VALUE    = 2499,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(DIV_VALUE + 1);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    slot_state_e             state_q, state_d;

    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic                    pend_valid_q, pend_valid_d;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    show;
    logic [6:0]              dec_seg;

    always_comb begin
        tick    = (cnt_q == CNT_W'(DIV_VALUE));
        wrap    = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        state_d = state_q;
        case (state_q)
            BLANK:   if (cnt_d == CNT_W'(BLANK_CYCLES)) state_d = SHOW;
            SHOW:    if (tick) state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    // A load on the wrap cycle bypasses pending so it is visible from slot 0.
    always_comb begin
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_en_d     = act_en_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        pend_valid_d = pend_valid_q;
        if (load) begin
            pend_data_d  = digit_data;
            pend_dp_d    = dp_in;
            pend_en_d    = digit_en;
            pend_valid_d = 1'b1;
        end
        if (wrap) begin
            if (load) begin
                act_data_d   = digit_data;
                act_dp_d     = dp_in;
                act_en_d     = digit_en;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                act_data_d   = pend_data_q;
                act_dp_d     = pend_dp_q;
                act_en_d     = pend_en_q;
                pend_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nibble = act_data_q[4*i +: 4];
                cur_dp     = act_dp_q[i];
                cur_en     = act_en_q[i];
            end
        end
    end

    hex_to_7seg u_dec (
        .nibble (cur_nibble),
        .seg_n  (dec_seg)
    );

    // A disabled digit still consumes its slot so brightness stays constant.
    always_comb begin
        show         = (state_q == SHOW) && cur_en;
        an_d         = show ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_d        = show ? dec_seg : SEG_BLANK;
        dp_d         = show ? ~cur_dp : 1'b1;
        frame_done_d = wrap;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= BLANK;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_valid_q <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_valid_q <= pend_valid_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: table of display loads checked slot by
// slot through a frame scoreboard, plus reset and random anode one-hot runs.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int DIV   = 9;
    localparam int BLK   = 2;
    localparam int SLOT  = DIV + 1;
    localparam int FRAME = ND * SLOT;
    localparam int NV    = 6;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b1;
    logic [15:0] digit_data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        load = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dpm;
        logic [3:0]      en;
        logic [3:0][6:0] seg;
        int              load_k;
        bit              decoy;
    } vec_t;

    typedef struct {
        logic [3:0]      dpm;
        logic [3:0]      en;
        logic [3:0][6:0] seg;
    } frame_t;

    vec_t   vecs [NV];
    frame_t exp_q [$];
    frame_t dark;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .DIV_VALUE    (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .digit_data (digit_data),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk_in = ~clk_in;

    // At most one anode may ever be driven low.
    always @(negedge clk_in) begin
        if (rst_n) begin
            checks++;
            if (an == 4'hF || $onehot(~an)) passes++;
            else $display("[TB] FAIL anode_onehot: an=%h, required all-ones or one zero bit", an);
        end
    end

    task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dpm, input logic [3:0] en);
        digit_data = data;
        dp_in      = dpm;
        digit_en   = en;
        load       = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] ean, input logic [6:0] eseg,
                               input logic edp, input logic efd);
        checks++;
        if (an === ean && seg === eseg && dp === edp && frame_done === efd) passes++;
        else $display("[TB] FAIL %s: got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=%b fd=%b",
                      name, an, seg, dp, frame_done, ean, eseg, edp, efd);
    endtask

    task automatic checkValue(input string name, input logic got, input logic want);
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s: got %b, want %b", name, got, want);
    endtask

    function automatic frame_t toFrame(input vec_t v);
        frame_t f;
        f.dpm = v.dpm;
        f.en  = v.en;
        f.seg = v.seg;
        return f;
    endfunction

    // Checks one full frame (edges 1..FRAME after the previous wrap) against the
    // oldest scoreboard entry, optionally loading new data along the way.
    task automatic runFrame(input vec_t v, input string tag);
        frame_t     cur;
        int         c;
        int         i;
        logic       show;
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       edp;
        if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL %s_scoreboard: got empty queue, want one frame", tag);
            cur = dark;
        end else begin
            cur = exp_q.pop_front();
        end
        for (int k = 1; k <= FRAME; k++) begin
            @(posedge clk_in);
            #1;
            load = 1'b0;
            c    = (k - 1) % SLOT;
            i    = (k - 1) / SLOT;
            show = (c >= BLK) && cur.en[i];
            ean  = show ? 4'(~(4'b0001 << i)) : 4'hF;
            eseg = show ? cur.seg[i] : 7'h7F;
            edp  = show ? ~cur.dpm[i] : 1'b1;
            checkOutput($sformatf("%s_k%0d", tag, k), ean, eseg, edp, k == FRAME);
            if (v.decoy && k == 5) applyStimulus(16'($urandom), 4'($urandom), 4'($urandom));
            if (k == v.load_k) begin
                applyStimulus(v.data, v.dpm, v.en);
                exp_q.push_back(toFrame(v));
            end
        end
        if (v.load_k < 1) exp_q.push_back(cur);
        if (v.load_k == FRAME - 1) checkValue({tag, "_pend_valid"}, dut.pend_valid_q, 1'b0);
    endtask

    initial begin
        dark.dpm = '0;
        dark.en  = '0;
        dark.seg = {4{7'h7F}};

        vecs[0] = '{16'h8421, 4'b0000, 4'b1111, {7'h00, 7'h19, 7'h24, 7'h79}, 15, 1'b0};
        vecs[1] = '{16'h1234, 4'b0000, 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 15, 1'b1};
        vecs[2] = '{16'hABCD, 4'b0000, 4'b1111, {7'h08, 7'h03, 7'h46, 7'h21}, FRAME - 1, 1'b0};
        vecs[3] = '{16'h5F60, 4'b0001, 4'b1011, {7'h12, 7'h0E, 7'h02, 7'h40}, 15, 1'b0};
        vecs[4] = '{16'h9E7C, 4'b1010, 4'b0110, {7'h10, 7'h06, 7'h78, 7'h46}, FRAME - 1, 1'b0};
        vecs[5] = '{16'h0000, 4'b0000, 4'b0000, {4{7'h7F}}, -1, 1'b0};

        #1 rst_n = 1'b0;
        #20;
        checkOutput("reset_hold", 4'hF, 7'h7F, 1'b1, 1'b0);
        @(posedge clk_in);
        #1 rst_n = 1'b1;

        exp_q.push_back(dark);
        for (int v = 0; v < NV; v++) runFrame(vecs[v], $sformatf("vec%0d", v));

        // Active data is vecs[4]; park a pending load, then reset in digit 1's SHOW window.
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk_in);
            #1;
            load = 1'b0;
            if (k == 5) applyStimulus(vecs[0].data, vecs[0].dpm, vecs[0].en);
        end
        checkOutput("pre_reset", 4'hD, 7'h78, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        @(posedge clk_in);
        #1 rst_n = 1'b1;
        exp_q.delete();
        exp_q.push_back(dark);
        runFrame(vecs[5], "post_reset0");
        runFrame(vecs[5], "post_reset1");

        for (int n = 0; n < 1000; n++) begin
            @(posedge clk_in);
            #1;
            load = 1'b0;
            if ($urandom_range(0, 9) == 0) applyStimulus(16'($urandom), 4'($urandom), 4'($urandom));
        end
        @(posedge clk_in);
        #1 load = 1'b0;

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
